// File: rtl/vga_capture_monitor_if.sv
// VGA capture monitor bus: sampled pin bus, error clear,
// reconstructed pixel stream and frame/timing status.
interface vga_capture_monitor_if;
  logic [7:0]  vga_in;
  logic        clear_err;
  logic        locked;
  logic        pixel_valid;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic [5:0]  rgb;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic [18:0] lit_count;
  logic [9:0]  h_total_meas;
  logic [9:0]  v_total_meas;
  logic        err_h;
  logic        err_v;

  modport master (
    output vga_in, clear_err,
    input  locked, pixel_valid, hpos, vpos, rgb,
    input  frame_done, frame_crc, lit_count,
    input  h_total_meas, v_total_meas, err_h, err_v
  );

  modport slave (
    input  vga_in, clear_err,
    output locked, pixel_valid, hpos, vpos, rgb,
    output frame_done, frame_crc, lit_count,
    output h_total_meas, v_total_meas, err_h, err_v
  );
endinterface

// File: rtl/vga_capture_monitor.sv
// VGA receive-side monitor: sync lock, pixel reconstruction,
// line/frame timing measurement and per-frame CRC/lit count.
module vga_capture_monitor #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic rst_n,
  vga_capture_monitor_if.slave bus
);
  localparam int HTOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  HD  = 10'(H_DISPLAY);
  localparam logic [9:0]  VD  = 10'(V_DISPLAY);
  localparam logic [9:0]  HT1 = 10'(HTOT - 1);
  localparam logic [9:0]  VT1 = 10'(VTOT - 1);
  localparam logic [9:0]  VTN = 10'(VTOT);
  localparam logic [9:0]  HSS = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  VSS = 10'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] HTN = 11'(HTOT);
  localparam logic [2:0]  LF  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_e;

  state_e      st_q, st_d;
  logic [2:0]  good_q, good_d;
  logic [7:0]  s1_q;
  logic        hsp_q, vsp_q;
  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [10:0] hper_q, hper_d;
  logic [9:0]  lcnt_q, lcnt_d;
  logic [9:0]  hmeas_q, hmeas_d;
  logic [9:0]  vmeas_q, vmeas_d;
  logic        hbad_q, hbad_d;
  logic        errh_q, errh_d;
  logic        errv_q, errv_d;
  logic        pv_q, pv_d;
  logic [9:0]  hpos_q, vpos_q;
  logic [5:0]  rgb_q, rgb_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] fcrc_q, fcrc_d;
  logic [18:0] lit_q, lit_d;
  logic [18:0] flit_q, flit_d;
  logic        fd_q, fd_d;

  logic hs_rise, vs_rise, hwrap;
  logic h_bad, frame_good;
  logic set_h, set_v;

  function automatic logic [15:0] crc6(
    input logic [15:0] c,
    input logic [5:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign hs_rise    = s1_q[7] & ~hsp_q;
  assign vs_rise    = s1_q[3] & ~vsp_q;
  assign hwrap      = !hs_rise && (hc_q == HT1);
  assign h_bad      = hs_rise && (hper_q != HTN);
  assign frame_good = !hbad_q && (lcnt_q == VTN);

  always_comb begin
    hc_d = hs_rise ? HSS : (hwrap ? 10'd0 : hc_q + 10'd1);
    vc_d = vc_q;
    if (vs_rise)
      vc_d = VSS;
    else if (hwrap)
      vc_d = (vc_q == VT1) ? 10'd0 : vc_q + 10'd1;

    // period counters saturate so a missing sync never wraps
    hper_d = hper_q;
    if (hs_rise)                hper_d = 11'd1;
    else if (hper_q < 11'd1023) hper_d = hper_q + 11'd1;
    hmeas_d = hs_rise ? hper_q[9:0] : hmeas_q;

    lcnt_d = lcnt_q;
    if (vs_rise)
      lcnt_d = {9'd0, hs_rise};
    else if (hs_rise && lcnt_q != 10'h3FF)
      lcnt_d = lcnt_q + 10'd1;
    vmeas_d = vs_rise ? lcnt_q : vmeas_q;
    hbad_d  = vs_rise ? h_bad : (hbad_q | h_bad);
  end

  always_comb begin
    pv_d  = (hc_d < HD) && (vc_d < VD) && (st_q != UNLOCKED);
    rgb_d = 6'd0;
    if (pv_d)
      rgb_d = {s1_q[0], s1_q[4], s1_q[1],
               s1_q[5], s1_q[2], s1_q[6]};

    crc_d = crc_q;
    lit_d = lit_q;
    if (pv_d && hc_d == 10'd0 && vc_d == 10'd0) begin
      crc_d = crc6(16'hFFFF, rgb_d);
      lit_d = {18'd0, |rgb_d};
    end else if (pv_d) begin
      crc_d = crc6(crc_q, rgb_d);
      lit_d = lit_q + {18'd0, |rgb_d};
    end

    fd_d = pv_q && (hpos_q == HD - 10'd1) &&
           (vpos_q == VD - 10'd1) && (st_q == LOCKED);
    fcrc_d = fd_d ? crc_q : fcrc_q;
    flit_d = fd_d ? lit_q : flit_q;
  end

  always_comb begin
    st_d   = st_q;
    good_d = good_q;
    set_h  = 1'b0;
    set_v  = 1'b0;
    unique case (st_q)
      UNLOCKED: begin
        if (vs_rise) begin
          st_d   = ACQUIRE;
          good_d = 3'd0;
        end
      end
      ACQUIRE: begin
        if (vs_rise) begin
          if (frame_good) begin
            good_d = good_q + 3'd1;
            if (good_d == LF) st_d = LOCKED;
          end else begin
            good_d = 3'd0;
          end
        end
      end
      LOCKED: begin
        set_h = h_bad;
        set_v = vs_rise && (lcnt_q != VTN);
        if (set_h || set_v) st_d = UNLOCKED;
      end
      default: st_d = UNLOCKED;
    endcase

    // a new error outranks a simultaneous clear
    errh_d = set_h ? 1'b1 : (bus.clear_err ? 1'b0 : errh_q);
    errv_d = set_v ? 1'b1 : (bus.clear_err ? 1'b0 : errv_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= UNLOCKED;
      good_q  <= 3'd0;
      s1_q    <= 8'd0;
      hsp_q   <= 1'b0;
      vsp_q   <= 1'b0;
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      hper_q  <= 11'd0;
      lcnt_q  <= 10'd0;
      hmeas_q <= 10'd0;
      vmeas_q <= 10'd0;
      hbad_q  <= 1'b0;
      errh_q  <= 1'b0;
      errv_q  <= 1'b0;
      pv_q    <= 1'b0;
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      rgb_q   <= 6'd0;
      crc_q   <= 16'hFFFF;
      fcrc_q  <= 16'd0;
      lit_q   <= 19'd0;
      flit_q  <= 19'd0;
      fd_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      good_q  <= good_d;
      s1_q    <= bus.vga_in;
      hsp_q   <= s1_q[7];
      vsp_q   <= s1_q[3];
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hper_q  <= hper_d;
      lcnt_q  <= lcnt_d;
      hmeas_q <= hmeas_d;
      vmeas_q <= vmeas_d;
      hbad_q  <= hbad_d;
      errh_q  <= errh_d;
      errv_q  <= errv_d;
      pv_q    <= pv_d;
      hpos_q  <= hc_d;
      vpos_q  <= vc_d;
      rgb_q   <= rgb_d;
      crc_q   <= crc_d;
      fcrc_q  <= fcrc_d;
      lit_q   <= lit_d;
      flit_q  <= flit_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.locked       = (st_q == LOCKED);
  assign bus.pixel_valid  = pv_q;
  assign bus.hpos         = hpos_q;
  assign bus.vpos         = vpos_q;
  assign bus.rgb          = rgb_q;
  assign bus.frame_done   = fd_q;
  assign bus.frame_crc    = fcrc_q;
  assign bus.lit_count    = flit_q;
  assign bus.h_total_meas = hmeas_q;
  assign bus.v_total_meas = vmeas_q;
  assign bus.err_h        = errh_q;
  assign bus.err_v        = errv_q;
endmodule

// File: doc/vga_capture_monitor.md
Name: vga_capture_monitor

Overview:
- Receive-side counterpart of the 640x480 VGA pixel generator. Samples the packed 8-bit VGA pin bus and locks to hsync/vsync edges.
- Reconstructs pixel coordinates and active-video strobes, and measures line/frame timing against nominal parameters.
- Computes a per-frame CRC-16 and lit-pixel count, so benches and on-chip self-test can check generated frames without a monitor.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch clocks
H_SYNC, 96, hsync width clocks
H_BACK, 48, horizontal back porch clocks
V_DISPLAY, 480, active lines
V_FRONT, 10, vertical front porch lines
V_SYNC, 2, vsync width lines
V_BACK, 33, vertical back porch lines
LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
clk  in  1  pixel clock, same clock as the source
rst_n  in  1  async active-low reset
vga_in  in  8  {hsync,B0,G0,R0,vsync,B1,G1,R1}, sync active-high
clear_err  in  1  synchronous pulse, clears sticky error flags
locked  out  1  timing lock achieved
pixel_valid  out  1  rgb/hpos/vpos hold an active pixel
hpos  out  10  reconstructed column
vpos  out  10  reconstructed row
rgb  out  6  {R1,R0,G1,G0,B1,B0} of current pixel
frame_done  out  1  one-cycle pulse after last active pixel of a frame while locked
frame_crc  out  16  CRC of the last completed frame
lit_count  out  19  nonzero pixels in the last completed frame
h_total_meas  out  10  clocks between the last two hsync rises
v_total_meas  out  10  hsync rises between the last two vsync rises
err_h  out  1  sticky: line length mismatch while locked
err_v  out  1  sticky: frame length mismatch while locked

Behaviour:
- Reset behaviour:
  - rst_n is asynchronous, active-low; clock is clk.
  - On reset, every output and register goes to 0, the state machine goes to UNLOCKED, and the CRC accumulator goes to 0xFFFF.
- Input sampling and latency:
  - vga_in is registered once (s1), and the previous sample is kept for edge detection.
  - A pin value sampled at edge t drives the rgb/hpos/vpos/pixel_valid registers at edge t+1, a 2-cycle pin-to-output latency.
- Horizontal counter (hc) for each s1 sample:
  - A sample with an hsync rise gets hc = H_DISPLAY+H_FRONT (656).
  - Otherwise hc = prev+1, wrapping from H_TOTAL-1 (799) to 0.
- Vertical counter (vc):
  - A sample with a vsync rise gets vc = H_DISPLAY-independent V_DISPLAY+V_FRONT (490).
  - Otherwise vc increments when hc wraps to 0, wrapping from V_TOTAL-1 (524) to 0.
  - A simultaneous hsync rise and vsync rise applies both loads.
- Pixel output:
  - pixel_valid = (hc < H_DISPLAY) && (vc < V_DISPLAY) && state != UNLOCKED.
  - When pixel_valid = 0, rgb = 0; hpos/vpos still track hc/vc.
- Timing measurement:
  - An 11-bit hsync period counter is loaded into h_total_meas on each hsync rise. It saturates at 1023 (not 2047), so h_total_meas never wraps.
  - A line counter is loaded into v_total_meas on each vsync rise, saturating at 1023.
- State machine:
  - UNLOCKED → ACQUIRE on the first vsync rise. The good-frame counter clears.
  - In ACQUIRE, on each vsync rise: if every hsync period in the frame equalled H_TOTAL and the line count equalled V_TOTAL, the good counter increments; otherwise it returns to 0.
  - ACQUIRE → LOCKED when the good counter reaches LOCK_FRAMES. locked asserts the cycle after that vsync rise.
  - LOCKED → UNLOCKED the cycle after any bad hsync period (sets err_h) or bad frame length (sets err_v).
  - A second vsync rise before 525 lines counts as a bad frame.
- Error flags:
  - err_h and err_v are set only while LOCKED.
  - clear_err clears them; a set condition in the same cycle as clear_err wins.
- CRC and lit count:
  - CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Each active pixel feeds its 6 bits MSB-first (R1 first), six bits per clock, unrolled.
  - The accumulator reinitialises at pixel (0,0).
  - lit_count increments for rgb != 0.
  - After pixel (639,479), frame_crc and lit_count are updated and frame_done pulses in the same cycle, only when locked.
  - Values persist until the next completed frame.
- Reset mid-frame: immediate clear, with a full reacquire needed (LOCK_FRAMES+1 vsync rises).

Test Plan:
1. Reset check: hold rst_n=0 with random vga_in → all outputs 0. Release, then apply no sync edges for 2000 clocks → locked=0, pixel_valid=0.
2. Nominal lock: 640x480 source, all-black frames → locked rises 1 clk after the 3rd vsync rise; h_total_meas=800, v_total_meas=525; lit_count=0; frame_crc matches the bench CRC model; no errors.
3. Single pixel: only (0,0)=6'h3F and (639,479)=6'h15 → pixel_valid with hpos=0, vpos=0, rgb=0x3F appears 2 clks after the pin value; lit_count=2; frame_done pulses once per frame.
4. Short line while locked: one line of 799 clks → h_total_meas=799, err_h=1, locked=0 the next clk. Pulse clear_err → err_h=0. Normal input then relocks after 3 vsync rises.
5. Short frame while locked: 524 lines → v_total_meas=524, err_v=1, locked drops. clear_err coinciding with a new error → flag stays 1.
6. Mid-frame reset: assert rst_n at line 200 → outputs 0 immediately; frame_done absent until relock completes.
